// File: rtl/mod_multiplier_feed_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_multiplier_feed_if
// Description : Start/operand/result handshake bundle for mod_multiplier_feed.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_multiplier_feed_if #(
    parameter int WIDTH = 16
) ();
    logic                 ready_in;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [2*WIDTH-1:0]   product_out;
    logic                 busy_out;
    logic                 valid_out;

    modport master (
        output ready_in, a_in, b_in,
        input  product_out, busy_out, valid_out
    );

    modport slave (
        input  ready_in, a_in, b_in,
        output product_out, busy_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/mod_multiplier_feed.sv
`default_nettype none
// ============================================================================
// Module      : mod_multiplier_feed
// Description : Sequential radix-4 unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
//               Optional MULT_EARLY_TERM_EN finishes once the multiplier is exhausted.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_multiplier_feed #(
    parameter int WIDTH = 16
) (
    input  wire logic         clk_in,
    input  wire logic         rst_n_in,
    mod_multiplier_feed_if.slave bus
);
    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;
    localparam int AW = WIDTH + 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t          r_state, w_state_nx;
    logic [AW-1:0]   r_a, w_a_nx;
    logic [AW-1:0]   r_a3, w_a3_nx;
    logic [WIDTH-1:0] r_b_sh, w_b_sh_nx;
    logic [PW-1:0]   r_acc, w_acc_nx;
    logic [PW-1:0]   r_product, w_product_nx;
    logic [CW-1:0]   r_count, w_count_nx;
    logic            r_busy, w_busy_nx;
    logic            r_valid, w_valid_nx;

    logic [AW-1:0]   w_pp_raw;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_sum;
    logic [WIDTH-1:0] w_b_shift;
    logic            w_last;

    // Partial product for the current bit pair, aligned to its radix-4 weight
    always_comb begin
        w_pp_raw = '0;
        case (r_b_sh[1:0])
            2'd0: w_pp_raw = '0;
            2'd1: w_pp_raw = r_a;
            2'd2: w_pp_raw = r_a << 1;
            2'd3: w_pp_raw = r_a3;
            default: w_pp_raw = '0;
        endcase
    end

    assign w_pp      = {{(PW-AW){1'b0}}, w_pp_raw} << {r_count, 1'b0};
    assign w_sum     = r_acc + w_pp;
    assign w_b_shift = r_b_sh >> 2;

`ifdef MULT_EARLY_TERM_EN
    assign w_last = (w_b_shift == '0) || (r_count == CW'(N - 1));
`else
    assign w_last = (r_count == CW'(N - 1));
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_a_nx       = r_a;
        w_a3_nx      = r_a3;
        w_b_sh_nx    = r_b_sh;
        w_acc_nx     = r_acc;
        w_product_nx = r_product;
        w_count_nx   = r_count;
        w_busy_nx    = r_busy;
        w_valid_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ready_in) begin
                    w_a_nx     = {2'b00, bus.a_in};
                    w_a3_nx    = ({2'b00, bus.a_in} << 1) + {2'b00, bus.a_in};
                    w_b_sh_nx  = bus.b_in;
                    w_acc_nx   = '0;
                    w_count_nx = '0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = MULT;
                end
            end
            MULT: begin
                w_acc_nx   = w_sum;
                w_b_sh_nx  = w_b_shift;
                w_count_nx = r_count + 1'b1;
                if (w_last) begin
                    w_product_nx = w_sum;
                    w_busy_nx    = 1'b0;
                    w_valid_nx   = 1'b1;
                    w_state_nx   = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_a3      <= '0;
            r_b_sh    <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_a       <= w_a_nx;
            r_a3      <= w_a3_nx;
            r_b_sh    <= w_b_sh_nx;
            r_acc     <= w_acc_nx;
            r_product <= w_product_nx;
            r_count   <= w_count_nx;
            r_busy    <= w_busy_nx;
            r_valid   <= w_valid_nx;
        end
    end

    assign bus.product_out = r_product;
    assign bus.busy_out    = r_busy;
    assign bus.valid_out   = r_valid;
endmodule
`default_nettype wire

// File: doc/mod_multiplier_feed.md
Name: mod_multiplier_feed

Overview:
- Sequential radix-4 unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Sits directly upstream of the modulus reduction stage. product_out connects to its value_in; valid_out connects to its ready_in.
- Retires 2 multiplier bits per cycle and reports status with the team's ready/busy/valid handshake.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and >= 4. Compute cycles N = WIDTH/2.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- ready_in  input  1  start request. Sampled only while idle.
- a_in  input  WIDTH  multiplicand. Sampled on the accept edge.
- b_in  input  WIDTH  multiplier. Sampled on the accept edge.
- product_out  output  2*WIDTH  registered a*b. Held until the next operation completes.
- busy_out  output  1  high while an operation is in flight.
- valid_out  output  1  one-cycle completion pulse.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n_in low immediately clears product_out=0, busy_out=0, valid_out=0, the accumulator, the operand registers and the count.
  - State returns to IDLE. No valid pulse results from a reset.
- States: IDLE, MULT.
- IDLE -> MULT on a rising edge with ready_in=1 (the accept edge E0). At E0:
  - latch a_in (zero-extended) and b_in into a shift register;
  - precompute 3a (WIDTH+2 bits) and clear the accumulator;
  - count <= 0, busy_out <= 1.
- MULT, each edge Ek (k=1..N):
  - take the low 2 bits d of the b shift register;
  - add d*a (0, a, 2a or 3a) shifted left by 2*(k-1) into the 2*WIDTH accumulator;
  - shift b right by 2; count increments.
- Arithmetic: accumulation is exact; no overflow is possible in 2*WIDTH bits. Result equals unsigned a_in*b_in.
- At EN: product_out <= final sum, busy_out <= 0, state -> IDLE.
- valid_out = 1 for exactly the one cycle after EN, i.e. the first cycle busy_out reads 0 following an operation. It is 0 otherwise.
  - It may be derived from a registered last-busy flag.
- Latency: valid_out is high in the cycle following edge E(N). WIDTH=16 gives 8 edges after accept. Throughput is one operation per N+1 cycles.
- ready_in while busy_out=1: ignored. Operands and result are unaffected.
- ready_in=1 during the valid_out cycle: accepted, because the block is idle.
  - product_out still shows the previous result during that cycle.
  - It keeps that value until the new EN.
- Operand inputs may change freely after E0.
- Reset mid-operation: the operation is aborted, outputs are zeroed, and the block is idle on release.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined: at any MULT edge Ek, if the b shift register is all-zero after the shift, that edge acts as EN.
  - product_out loads the final sum, busy_out drops, and valid_out pulses the next cycle.
  - Minimum is one compute edge. b_in=0 finishes at E1.
  - Latency becomes data-dependent: (index of the highest nonzero bit pair) + 1 edges.
- Undefined: fixed N compute edges regardless of operand values.

Test Plan:
- Reset: assert rst_n_in asynchronously between clock edges -> product_out=0, busy_out=0 and valid_out=0 immediately; no pulse after release.
- WIDTH=16, a=0xFFFF, b=0xFFFF:
  - busy_out is high for 8 cycles after E0;
  - valid_out pulses once in the cycle after E8;
  - product_out=0xFFFE0001.
- a=0x0003, b=0x0005, with ready_in held high and operands changed to 0xAAAA/0x5555 during busy -> result 0x0000000F, with no second accept until the valid cycle.
  - Back-to-back: the second operation is accepted in the valid cycle and yields 0x38E31C72 eight edges later.
- Abort: start 0x1234*0x5678 and pull rst_n_in low after E4 -> outputs zero with no valid pulse.
  - Then 0x1234*0x0002 -> 0x00002468.
- Integration: 0x1234*0x5678 -> product_out=0x06260060. Feed it to the downstream modulus stage with modulus 0x00FB -> final residue 0x0027.
- MULT_EARLY_TERM_EN:
  - a=0x00FF, b=0x0001 -> valid one cycle after E1, product_out=0x000000FF;
  - b=0x0000 -> valid one cycle after E1, product_out=0;
  - without the macro, the same stimulus takes 8 edges with identical results.
